// File: rtl/midi_pkg.sv
// Shared MIDI definitions: byte-class boundaries, decoder states and the
// status-to-data-length rule used by both the receive and transmit sides.
package midi_pkg;

  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] SYSCOM_MIN = 8'hF0;
  localparam logic [7:0] RT_MIN     = 8'hF8;
  localparam logic [7:0] SX_START   = 8'hF0;
  localparam logic [7:0] SX_END     = 8'hF7;

  // Length code returned for bytes that do not start a sized message
  // (data bytes, F0, F4, F5, F7, real-time).
  localparam logic [1:0] LEN_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } midi_state_e;

  typedef enum logic [1:0] {
    CLS_DATA   = 2'd0,
    CLS_CHAN   = 2'd1,
    CLS_SYSCOM = 2'd2,
    CLS_RT     = 2'd3
  } midi_class_e;

  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = LEN_INVALID;
    if (status >= STATUS_MIN && status < SYSCOM_MIN) begin
      case (status[7:4])
        4'hC, 4'hD: len = 2'd1;
        default:    len = 2'd2;
      endcase
    end else begin
      case (status)
        8'hF1, 8'hF3: len = 2'd1;
        8'hF2:        len = 2'd2;
        8'hF6:        len = 2'd0;
        default:      len = LEN_INVALID;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_len_lut.sv
// Combinational byte classifier: byte class plus expected data length.
module midi_len_lut
  import midi_pkg::*;
(
  input  logic [7:0] status_i,
  output logic [1:0] cls_o,
  output logic [1:0] len_o,
  output logic       len_ok_o
);

  // Classify by range and look up the data length for sized statuses.
  always_comb begin
    len_o    = midi_data_len(status_i);
    len_ok_o = (len_o != LEN_INVALID);
    if (status_i < STATUS_MIN) begin
      cls_o = CLS_DATA;
    end else if (status_i < SYSCOM_MIN) begin
      cls_o = CLS_CHAN;
    end else if (status_i < RT_MIN) begin
      cls_o = CLS_SYSCOM;
    end else begin
      cls_o = CLS_RT;
    end
  end

endmodule

// File: rtl/midi_msg_decoder.sv
// Receive-side MIDI byte-stream decoder: assembles channel and system-common
// messages with running status, forwards real-time bytes and streams SysEx.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no message in progress
// ST_WAIT_D1 | status seen, waiting for first data byte
// ST_WAIT_D2 | first data byte held in d1_q, waiting for second
// ST_SYSEX   | inside SysEx, data bytes are payload
module midi_msg_decoder
  import midi_pkg::*;
#(
  parameter bit SYSEX_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       sx_valid,
  output logic [6:0] sx_data,
  output logic       sx_end,
  output logic       err_drop
);

  midi_state_e state_q, state_d;
  logic [7:0]  rs_q, rs_d;
  logic        rs_vld_q, rs_vld_d;
  logic [7:0]  cur_st_q, cur_st_d;
  logic [1:0]  cur_len_q, cur_len_d;
  logic [6:0]  d1_q, d1_d;

  logic        msg_valid_q, msg_valid_d;
  logic [7:0]  msg_status_q, msg_status_d;
  logic [6:0]  msg_data1_q, msg_data1_d;
  logic [6:0]  msg_data2_q, msg_data2_d;
  logic [1:0]  msg_len_q, msg_len_d;
  logic        rt_valid_q, rt_valid_d;
  logic [7:0]  rt_byte_q, rt_byte_d;
  logic        sx_valid_q, sx_valid_d;
  logic [6:0]  sx_data_q, sx_data_d;
  logic        sx_end_q, sx_end_d;
  logic        err_drop_q, err_drop_d;

  logic [1:0]  in_cls;
  logic [1:0]  in_len;
  logic        in_len_ok;
  logic        idle_proc;

  midi_len_lut u_len_lut (
    .status_i (in_data),
    .cls_o    (in_cls),
    .len_o    (in_len),
    .len_ok_o (in_len_ok)
  );

  // Next-state and response logic for one received byte. A status byte that
  // interrupts a partial message or SysEx sets idle_proc so it is handled
  // exactly as if it had arrived in IDLE, within the same cycle.
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    rs_vld_d     = rs_vld_q;
    cur_st_d     = cur_st_q;
    cur_len_d    = cur_len_q;
    d1_d         = d1_q;
    msg_valid_d  = 1'b0;
    msg_status_d = msg_status_q;
    msg_data1_d  = msg_data1_q;
    msg_data2_d  = msg_data2_q;
    msg_len_d    = msg_len_q;
    rt_valid_d   = 1'b0;
    rt_byte_d    = rt_byte_q;
    sx_valid_d   = 1'b0;
    sx_data_d    = sx_data_q;
    sx_end_d     = 1'b0;
    err_drop_d   = 1'b0;
    idle_proc    = 1'b0;

    if (in_valid) begin
      if (in_cls == CLS_RT) begin
        rt_valid_d = 1'b1;
        rt_byte_d  = in_data;
      end else begin
        case (state_q)
          ST_SYSEX: begin
            if (in_cls == CLS_DATA) begin
              if (SYSEX_EN) begin
                sx_valid_d = 1'b1;
                sx_data_d  = in_data[6:0];
              end
            end else if (in_data == SX_END) begin
              sx_end_d = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              sx_end_d  = 1'b1;
              idle_proc = 1'b1;
            end
          end
          ST_WAIT_D1: begin
            if (in_cls == CLS_DATA) begin
              if (cur_len_q == 2'd1) begin
                msg_valid_d  = 1'b1;
                msg_status_d = cur_st_q;
                msg_data1_d  = in_data[6:0];
                msg_data2_d  = 7'd0;
                msg_len_d    = 2'd1;
                state_d      = ST_IDLE;
              end else begin
                d1_d    = in_data[6:0];
                state_d = ST_WAIT_D2;
              end
            end else begin
              err_drop_d = 1'b1;
              idle_proc  = 1'b1;
            end
          end
          ST_WAIT_D2: begin
            if (in_cls == CLS_DATA) begin
              msg_valid_d  = 1'b1;
              msg_status_d = cur_st_q;
              msg_data1_d  = d1_q;
              msg_data2_d  = in_data[6:0];
              msg_len_d    = 2'd2;
              state_d      = ST_IDLE;
            end else begin
              err_drop_d = 1'b1;
              idle_proc  = 1'b1;
            end
          end
          default: idle_proc = 1'b1;
        endcase

        if (idle_proc) begin
          state_d = ST_IDLE;
          case (in_cls)
            CLS_DATA: begin
              if (rs_vld_q) begin
                if (midi_data_len(rs_q) == 2'd1) begin
                  msg_valid_d  = 1'b1;
                  msg_status_d = rs_q;
                  msg_data1_d  = in_data[6:0];
                  msg_data2_d  = 7'd0;
                  msg_len_d    = 2'd1;
                end else begin
                  cur_st_d  = rs_q;
                  cur_len_d = 2'd2;
                  d1_d      = in_data[6:0];
                  state_d   = ST_WAIT_D2;
                end
              end else begin
                err_drop_d = 1'b1;
              end
            end
            CLS_CHAN: begin
              rs_d      = in_data;
              rs_vld_d  = 1'b1;
              cur_st_d  = in_data;
              cur_len_d = in_len;
              state_d   = ST_WAIT_D1;
            end
            default: begin
              // System common: never becomes running status, and clears it.
              rs_d     = 8'h00;
              rs_vld_d = 1'b0;
              if (in_data == SX_START) begin
                state_d = ST_SYSEX;
              end else if (in_len_ok) begin
                if (in_len == 2'd0) begin
                  msg_valid_d  = 1'b1;
                  msg_status_d = in_data;
                  msg_data1_d  = 7'd0;
                  msg_data2_d  = 7'd0;
                  msg_len_d    = 2'd0;
                end else begin
                  cur_st_d  = in_data;
                  cur_len_d = in_len;
                  state_d   = ST_WAIT_D1;
                end
              end
            end
          endcase
        end
      end
    end
  end

  // State and registered outputs; reset discards any partial message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rs_q         <= 8'h00;
      rs_vld_q     <= 1'b0;
      cur_st_q     <= 8'h00;
      cur_len_q    <= 2'd0;
      d1_q         <= 7'd0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= 8'h00;
      msg_data1_q  <= 7'd0;
      msg_data2_q  <= 7'd0;
      msg_len_q    <= 2'd0;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'h00;
      sx_valid_q   <= 1'b0;
      sx_data_q    <= 7'd0;
      sx_end_q     <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs_q         <= rs_d;
      rs_vld_q     <= rs_vld_d;
      cur_st_q     <= cur_st_d;
      cur_len_q    <= cur_len_d;
      d1_q         <= d1_d;
      msg_valid_q  <= msg_valid_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      msg_len_q    <= msg_len_d;
      rt_valid_q   <= rt_valid_d;
      rt_byte_q    <= rt_byte_d;
      sx_valid_q   <= sx_valid_d;
      sx_data_q    <= sx_data_d;
      sx_end_q     <= sx_end_d;
      err_drop_q   <= err_drop_d;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_status = msg_status_q;
  assign msg_data1  = msg_data1_q;
  assign msg_data2  = msg_data2_q;
  assign msg_len    = msg_len_q;
  assign rt_valid   = rt_valid_q;
  assign rt_byte    = rt_byte_q;
  assign sx_valid   = sx_valid_q;
  assign sx_data    = sx_data_q;
  assign sx_end     = sx_end_q;
  assign err_drop   = err_drop_q;

endmodule
